seq_arm_detect_param: RTL

- Parametrised successor of the fixed "find 001 first, then find 1010" detector.
- Serial bit-stream monitor, two phases:
  - Arm phase: waits for a programmable ARM pattern.
  - Detect phase: flags every occurrence of a programmable DET pattern, with overlap or non-overlap counting.
- Also provides a saturating match counter, a one-cycle match pulse and a sample history for display logic.
- Sits between a debounced key/switch sampler and board LED/7-seg drivers.

---
 rtl/seq_arm_detect_param_if.sv | 24 ++
 rtl/seq_arm_detect_param.sv | 110 +++++++++++
 2 files changed

// File: rtl/seq_arm_detect_param_if.sv
// rtl/seq_arm_detect_param_if.sv - sample-stream and match-status bundle for the arm/detect monitor
interface seq_arm_detect_param_if #(
    parameter int COUNT_W = 8,
    parameter int HIST_W  = 8
);
    logic               en;
    logic               inp;
    logic               clear;
    logic               armed;
    logic               match;
    logic               match_pulse;
    logic [COUNT_W-1:0] match_count;
    logic [HIST_W-1:0]  history;

    modport master (
        output en, inp, clear,
        input  armed, match, match_pulse, match_count, history
    );

    modport slave (
        input  en, inp, clear,
        output armed, match, match_pulse, match_count, history
    );
endinterface

// File: rtl/seq_arm_detect_param.sv
// rtl/seq_arm_detect_param.sv - serial monitor: wait for ARM_PATTERN, then flag every DET_PATTERN
module seq_arm_detect_param #(
    parameter int                   ARM_LEN     = 3,
    parameter logic [ARM_LEN-1:0]   ARM_PATTERN = 3'b001,
    parameter int                   DET_LEN     = 4,
    parameter logic [DET_LEN-1:0]   DET_PATTERN = 4'b1010,
    parameter bit                   OVERLAP     = 1'b1,
    parameter int                   COUNT_W     = 8,
    parameter int                   HIST_W      = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    seq_arm_detect_param_if.slave  bus
);
    localparam int FW = $clog2(HIST_W + 1);

    typedef enum logic {
        S_ARM,
        S_DET
    } state_t;

    state_t             state_q, state_d;
    logic [HIST_W-1:0]  hist_q, hist_d;
    logic [FW-1:0]      arm_fill_q, arm_fill_d;
    logic [FW-1:0]      det_fill_q, det_fill_d;
    logic               match_q, match_d;
    logic               pulse_q, pulse_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic [HIST_W-1:0]  hist_shift;
    logic [FW-1:0]      arm_fill_inc;
    logic [FW-1:0]      det_fill_inc;
    logic               arm_hit;
    logic               det_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_ARM;
            hist_q     <= '0;
            arm_fill_q <= '0;
            det_fill_q <= '0;
            match_q    <= 1'b0;
            pulse_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            arm_fill_q <= arm_fill_d;
            det_fill_q <= det_fill_d;
            match_q    <= match_d;
            pulse_q    <= pulse_d;
            count_q    <= count_d;
        end
    end

    // Fill counters keep reset-zero history bits from posing as real samples.
    always_comb begin
        hist_shift   = {hist_q[HIST_W-2:0], bus.inp};
        arm_fill_inc = (arm_fill_q == FW'(HIST_W)) ? arm_fill_q : arm_fill_q + FW'(1);
        det_fill_inc = (det_fill_q == FW'(HIST_W)) ? det_fill_q : det_fill_q + FW'(1);
        arm_hit      = (arm_fill_inc >= FW'(ARM_LEN)) &&
                       (hist_shift[ARM_LEN-1:0] == ARM_PATTERN);
        // Arm samples may also open the first detect pattern.
        det_hit      = ((state_q == S_DET) || arm_hit) &&
                       (det_fill_inc >= FW'(DET_LEN)) &&
                       (hist_shift[DET_LEN-1:0] == DET_PATTERN);
    end

    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        arm_fill_d = arm_fill_q;
        det_fill_d = det_fill_q;
        match_d    = match_q;
        pulse_d    = 1'b0;
        count_d    = count_q;

        if (bus.clear) begin
            state_d    = S_ARM;
            hist_d     = '0;
            arm_fill_d = '0;
            det_fill_d = '0;
            match_d    = 1'b0;
            count_d    = '0;
        end else if (bus.en) begin
            hist_d     = hist_shift;
            arm_fill_d = arm_fill_inc;
            det_fill_d = det_fill_inc;
            match_d    = det_hit;
            pulse_d    = det_hit;
            if (state_q == S_ARM && arm_hit) begin
                state_d = S_DET;
            end
            if (det_hit) begin
                if (count_q != '1) begin
                    count_d = count_q + COUNT_W'(1);
                end
                if (!OVERLAP) begin
                    det_fill_d = '0;
                end
            end
        end
    end

    assign bus.armed       = (state_q == S_DET);
    assign bus.match       = match_q;
    assign bus.match_pulse = pulse_q;
    assign bus.match_count = count_q;
    assign bus.history     = hist_q;
endmodule
